// File: rtl/mp_pkg.sv
// Shared types and defaults for the ModuloProduct arbiter slice.
package mp_pkg;

  localparam int MP_WIDTH_DEF = 256;
  localparam int MP_KW_DEF    = 9;

  // Sequencer states: accept, start the unit, wait for it, respond.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } mp_state_t;

  // Request bundle at the default widths; the top builds the same bundle
  // at its own parameterised widths.
  typedef struct packed {
    logic [MP_WIDTH_DEF-1:0] N;
    logic [MP_WIDTH_DEF-1:0] a;
    logic [MP_WIDTH_DEF-1:0] b;
    logic [MP_KW_DEF-1:0]    k;
  } mp_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester after last_grant wins a tie.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt,
  output logic       o_any
);

  // Priority rotates away from whoever was granted last.
  always_comb begin
    o_gnt = 2'b00;
    if (i_last_grant) begin
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
    end else begin
      if (i_req[1])      o_gnt = 2'b10;
      else if (i_req[0]) o_gnt = 2'b01;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mp_arbiter.sv
// Shares one ModuloProduct unit between two requesters: arbitrate, latch the
// operands, pulse the unit once, wait under a watchdog, return the tagged result.
module mp_arbiter
  import mp_pkg::*;
#(
  parameter int WIDTH   = MP_WIDTH_DEF,
  parameter int KW      = MP_KW_DEF,
  parameter int TIMEOUT = 600
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_req_valid,
  output logic [1:0]             o_req_ready,
  input  logic [1:0][WIDTH-1:0]  i_req_N,
  input  logic [1:0][WIDTH-1:0]  i_req_a,
  input  logic [1:0][WIDTH-1:0]  i_req_b,
  input  logic [1:0][KW-1:0]     i_req_k,
  output logic [1:0]             o_rsp_valid,
  output logic [WIDTH-1:0]       o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_mp_rst,
  output logic                   o_mp_valid,
  output logic [WIDTH-1:0]       o_mp_N,
  output logic [WIDTH-1:0]       o_mp_a,
  output logic [WIDTH-1:0]       o_mp_b,
  output logic [KW-1:0]          o_mp_k,
  input  logic [WIDTH-1:0]       i_mp_result,
  input  logic                   i_mp_ready,
  output logic                   o_busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
  } req_t;

  mp_state_t        state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  req_t             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             abort_q, abort_d;

  logic [1:0]       gnt;
  logic             gnt_any;

  rr_arb2 u_arb (
    .i_req        (i_req_valid),
    .i_last_grant (last_grant_q),
    .o_gnt        (gnt),
    .o_any        (gnt_any)
  );

  // Next-state, operand latch, watchdog and strobe decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    abort_d      = 1'b0;
    o_req_ready  = 2'b00;
    o_mp_valid   = 1'b0;
    o_rsp_valid  = 2'b00;

    case (state_q)
      S_IDLE: begin
        o_req_ready = gnt;
        if (gnt_any) begin
          owner_d      = gnt[1];
          last_grant_d = gnt[1];
          op_d.N       = i_req_N[gnt[1]];
          op_d.a       = i_req_a[gnt[1]];
          op_d.b       = i_req_b[gnt[1]];
          op_d.k       = i_req_k[gnt[1]];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mp_valid = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the expiry cycle still counts as a good result.
        if (i_mp_ready) begin
          rsp_data_d = i_mp_result;
          rsp_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          abort_d    = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        o_rsp_valid = owner_q ? 2'b10 : 2'b01;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      abort_q      <= abort_d;
    end
  end

  assign o_mp_N     = op_q.N;
  assign o_mp_a     = op_q.a;
  assign o_mp_b     = op_q.b;
  assign o_mp_k     = op_q.k;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;
  assign o_mp_rst   = i_rst | abort_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mp_arbiter.sv
// Self-checking bench for mp_arbiter: ModuloProduct stub, two requester
// drivers, a transaction-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_mp_arbiter;
  import mp_pkg::*;

  localparam int WIDTH   = 256;
  localparam int KW      = 9;
  localparam int TIMEOUT = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic [1:0]            req_valid, req_ready, rsp_valid;
  logic [1:0][WIDTH-1:0] req_N, req_a, req_b;
  logic [1:0][KW-1:0]    req_k;
  logic [WIDTH-1:0]      rsp_data, mp_N, mp_a, mp_b, mp_result;
  logic [KW-1:0]         mp_k;
  logic                  rsp_err, mp_rst, mp_valid, mp_ready, busy;

  mp_arbiter #(.WIDTH(WIDTH), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_N(req_N), .i_req_a(req_a), .i_req_b(req_b), .i_req_k(req_k),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_mp_rst(mp_rst), .o_mp_valid(mp_valid),
    .o_mp_N(mp_N), .o_mp_a(mp_a), .o_mp_b(mp_b), .o_mp_k(mp_k),
    .i_mp_result(mp_result), .i_mp_ready(mp_ready), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] modprod(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    p = p % {{WIDTH{1'b0}}, n};
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] v = '0;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- ModuloProduct stub (latency L; 0 = never answers) ----------------
  int               stub_lat = 20;
  int               stub_cnt = 0;
  logic             stub_busy = 1'b0;
  logic             stub_ready = 1'b0;
  logic [WIDTH-1:0] stub_res = '0;
  logic             stray_ready = 1'b0;
  logic [WIDTH-1:0] stray_data = '0;

  always @(posedge clk) begin
    stub_ready <= 1'b0;
    if (mp_rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (mp_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 1;
      stub_res  <= modprod(mp_N, mp_a, mp_b);
    end else if (stub_busy) begin
      if (stub_lat != 0 && stub_cnt == stub_lat - 1) begin
        stub_ready <= 1'b1;
        stub_busy  <= 1'b0;
      end
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign mp_ready  = stub_ready | stray_ready;
  assign mp_result = stray_ready ? stray_data : stub_res;

  // ---------------- requester drivers ----------------
  typedef struct {
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
    int               gap;
  } job_t;

  job_t             jq[2][$];
  logic             drv_v[2];
  logic [WIDTH-1:0] drv_N[2], drv_a[2], drv_b[2];
  logic [KW-1:0]    drv_k[2];

  assign req_valid = {drv_v[1], drv_v[0]};
  assign req_N     = {drv_N[1], drv_N[0]};
  assign req_a     = {drv_a[1], drv_a[0]};
  assign req_b     = {drv_b[1], drv_b[0]};
  assign req_k     = {drv_k[1], drv_k[0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_drv
    initial begin
      job_t j;
      int   wcnt;
      drv_v[gi] = 1'b0;
      drv_N[gi] = '0;
      drv_a[gi] = '0;
      drv_b[gi] = '0;
      drv_k[gi] = '0;
      forever begin
        @(posedge clk); #2;
        if (jq[gi].size() == 0) begin
          drv_v[gi] = 1'b0;
        end else begin
          j = jq[gi].pop_front();
          drv_v[gi] = 1'b0;
          repeat (j.gap) begin @(posedge clk); #2; end
          drv_v[gi] = 1'b1;
          drv_N[gi] = j.N;
          drv_a[gi] = j.a;
          drv_b[gi] = j.b;
          drv_k[gi] = j.k;
          wcnt = 0;
          @(negedge clk);
          while (!req_ready[gi] && wcnt < 3000) begin @(negedge clk); wcnt++; end
          checks++;
          if (!req_ready[gi]) begin
            errors++;
            $display("FAIL accept_wait_%0d: no ready after %0d cycles, required accept", gi, wcnt);
          end
        end
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct {
    int               owner;
    logic [WIDTH-1:0] data;
    logic             err;
    int               cyc;
  } rsp_t;

  rsp_t rsp_log[$];
  int   acc_owner[$];
  int   acc_cyc[$];
  int   mp_rst_pulses = 0;

  initial begin : compare
    bit               m_idle, m_done;
    int               m_t, m_owner, m_last, g;
    logic [WIDTH-1:0] mN, ma, mb, m_data;
    logic [KW-1:0]    mk;
    logic             m_err;
    logic [1:0]       e_ready, e_rsp;
    logic             e_mpv, e_mprst;
    rsp_t             r;
    m_idle = 1; m_done = 0; m_t = 0; m_owner = 0; m_last = 1;
    mN = '0; ma = '0; mb = '0; mk = '0; m_data = '0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("mp_rst_in_reset", WIDTH'(mp_rst), WIDTH'(1));
        m_idle = 1; m_done = 0; m_t = 0; m_owner = 0; m_last = 1;
        mN = '0; ma = '0; mb = '0; mk = '0; m_data = '0; m_err = 1'b0;
      end else begin
        e_ready = 2'b00; e_rsp = 2'b00; e_mpv = 1'b0; e_mprst = 1'b0; g = -1;
        if (m_idle) begin
          if (m_last == 1) begin
            if (req_valid[0]) g = 0; else if (req_valid[1]) g = 1;
          end else begin
            if (req_valid[1]) g = 1; else if (req_valid[0]) g = 0;
          end
          if (g >= 0) e_ready[g] = 1'b1;
        end else if (m_done) begin
          e_rsp[m_owner] = 1'b1;
          e_mprst = m_err;
        end else if (m_t == 1) begin
          e_mpv = 1'b1;
        end

        chk("req_ready", WIDTH'(req_ready), WIDTH'(e_ready));
        chk("mp_valid",  WIDTH'(mp_valid),  WIDTH'(e_mpv));
        chk("rsp_valid", WIDTH'(rsp_valid), WIDTH'(e_rsp));
        chk("mp_rst",    WIDTH'(mp_rst),    WIDTH'(e_mprst));
        chk("busy",      WIDTH'(busy),      WIDTH'(!m_idle));
        chk("rsp_data",  rsp_data,          m_data);
        chk("rsp_err",   WIDTH'(rsp_err),   WIDTH'(m_err));
        chk("mp_N",      mp_N,              mN);
        chk("mp_a",      mp_a,              ma);
        chk("mp_b",      mp_b,              mb);
        chk("mp_k",      WIDTH'(mp_k),      WIDTH'(mk));

        if (req_ready != 2'b00) begin
          acc_owner.push_back(int'(req_ready[1]));
          acc_cyc.push_back(cyc);
        end
        if (rsp_valid != 2'b00) begin
          r.owner = int'(rsp_valid[1]); r.data = rsp_data; r.err = rsp_err; r.cyc = cyc;
          rsp_log.push_back(r);
          $display("rsp: requester %0d data %0h err %0b cycle %0d", r.owner, r.data, r.err, r.cyc);
        end
        if (mp_rst) mp_rst_pulses++;

        // Advance by cycles elapsed since the accept.
        if (m_idle) begin
          if (g >= 0) begin
            mN = req_N[g]; ma = req_a[g]; mb = req_b[g]; mk = req_k[g];
            m_owner = g; m_last = g; m_idle = 0; m_t = 1;
          end
        end else if (m_done) begin
          m_idle = 1; m_done = 0;
        end else if (m_t >= 2 && mp_ready) begin
          m_data = modprod(mN, ma, mb); m_err = 1'b0; m_done = 1;
        end else if (m_t == TIMEOUT + 1) begin
          m_data = '0; m_err = 1'b1; m_done = 1;
        end else begin
          m_t++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic job_t mk_job(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [KW-1:0] k, input int gap);
    job_t j;
    j.N = n; j.a = a; j.b = b; j.k = k; j.gap = gap;
    return j;
  endfunction

  function automatic job_t rand_job(input int gap);
    return mk_job(rand_wide() | WIDTH'(1), rand_wide(), rand_wide(), KW'($urandom_range(1, 256)), gap);
  endfunction

  task automatic wait_rsp(input int n, input int budget, input string nm);
    int c = 0;
    while (rsp_log.size() < n && c < budget) begin @(negedge clk); c++; end
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_log.size() < n) begin
      errors++;
      $display("FAIL %s: %0d responses seen, required %0d", nm, rsp_log.size(), n);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : main
    int   base, abase, pbase, nq;
    job_t j;
    logic [WIDTH-1:0] exp_d;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",      WIDTH'(busy),      WIDTH'(0));
    chk("reset_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    chk("reset_rsp_data",  rsp_data,          WIDTH'(0));
    chk("reset_mp_N",      mp_N,              WIDTH'(0));
    chk("reset_mp_rst",    WIDTH'(mp_rst),    WIDTH'(0));

    // 1: single request, latency 20
    stub_lat = 20;
    base = rsp_log.size(); abase = acc_cyc.size();
    jq[0].push_back(mk_job(WIDTH'(18795), WIDTH'(1000), WIDTH'(1000), KW'(14), 0));
    wait_rsp(base + 1, 200, "t1_wait");
    chk("t1_owner",   WIDTH'(rsp_log[base].owner), WIDTH'(0));
    chk("t1_data",    rsp_log[base].data,          WIDTH'(3865));
    chk("t1_err",     WIDTH'(rsp_log[base].err),   WIDTH'(0));
    chk("t1_latency", WIDTH'(rsp_log[base].cyc - acc_cyc[abase]), WIDTH'(22));

    // 2: simultaneous after reset, requester 0 first
    do_reset(2);
    base = rsp_log.size();
    jq[0].push_back(mk_job(WIDTH'(18795), WIDTH'(1000), WIDTH'(1000), KW'(14), 0));
    jq[1].push_back(mk_job(WIDTH'(18795), WIDTH'(2), WIDTH'(9400), KW'(2), 0));
    wait_rsp(base + 2, 300, "t2_wait");
    chk("t2_owner0", WIDTH'(rsp_log[base].owner),     WIDTH'(0));
    chk("t2_data0",  rsp_log[base].data,              WIDTH'(3865));
    chk("t2_owner1", WIDTH'(rsp_log[base + 1].owner), WIDTH'(1));
    chk("t2_data1",  rsp_log[base + 1].data,          WIDTH'(5));

    // 3: continuous contention alternates grants
    stub_lat = $urandom_range(2, 30);
    base = rsp_log.size(); abase = acc_owner.size();
    for (int i = 0; i < 3; i++) begin
      jq[0].push_back(rand_job(0));
      jq[1].push_back(rand_job(0));
    end
    wait_rsp(base + 6, 600, "t3_wait");
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), WIDTH'(acc_owner[abase + i]), WIDTH'(i % 2));

    // 4: timeout, then a normal request
    stub_lat = 0;
    base = rsp_log.size(); abase = acc_cyc.size(); pbase = mp_rst_pulses;
    jq[0].push_back(rand_job(0));
    wait_rsp(base + 1, 800, "t4_wait");
    chk("t4_err",     WIDTH'(rsp_log[base].err), WIDTH'(1));
    chk("t4_data",    rsp_log[base].data,        WIDTH'(0));
    chk("t4_latency", WIDTH'(rsp_log[base].cyc - acc_cyc[abase]), WIDTH'(TIMEOUT + 2));
    chk("t4_mp_rst_pulses", WIDTH'(mp_rst_pulses - pbase), WIDTH'(1));
    stub_lat = 10;
    j = rand_job(0);
    exp_d = modprod(j.N, j.a, j.b);
    jq[1].push_back(j);
    wait_rsp(base + 2, 200, "t4b_wait");
    chk("t4b_err",  WIDTH'(rsp_log[base + 1].err), WIDTH'(0));
    chk("t4b_data", rsp_log[base + 1].data,        exp_d);

    // 5: ready on the exact expiry cycle wins
    stub_lat = TIMEOUT;
    base = rsp_log.size(); abase = acc_cyc.size();
    jq[0].push_back(mk_job(WIDTH'(18795), WIDTH'(1000), WIDTH'(1000), KW'(14), 0));
    wait_rsp(base + 1, 800, "t5_wait");
    chk("t5_err",     WIDTH'(rsp_log[base].err), WIDTH'(0));
    chk("t5_data",    rsp_log[base].data,        WIDTH'(3865));
    chk("t5_latency", WIDTH'(rsp_log[base].cyc - acc_cyc[abase]), WIDTH'(TIMEOUT + 2));

    // 6: reset mid-WAIT drops the transaction; stray ready ignored
    stub_lat = 50;
    base = rsp_log.size(); abase = acc_cyc.size();
    jq[0].push_back(rand_job(0));
    nq = 0;
    while (acc_cyc.size() == abase && nq < 100) begin @(negedge clk); nq++; end
    repeat (10) @(negedge clk);
    do_reset(1);
    @(negedge clk);
    chk("t6_busy_after_rst", WIDTH'(busy), WIDTH'(0));
    repeat (5) @(posedge clk);
    #2 stray_ready = 1'b1; stray_data = rand_wide();
    @(posedge clk);
    #2 stray_ready = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_no_rsp", WIDTH'(rsp_log.size() - base), WIDTH'(0));
    chk("t6_idle",   WIDTH'(busy),                  WIDTH'(0));
    abase = acc_owner.size();
    jq[1].push_back(rand_job(0));
    jq[0].push_back(rand_job(0));
    wait_rsp(base + 2, 400, "t6_wait");
    chk("t6_first_grant",  WIDTH'(acc_owner[abase]),     WIDTH'(0));
    chk("t6_second_grant", WIDTH'(acc_owner[abase + 1]), WIDTH'(1));

    // 7: randomized traffic, checked cycle by cycle against the model
    for (int batch = 0; batch < 2; batch++) begin
      stub_lat = $urandom_range(2, 40);
      base = rsp_log.size();
      for (int i = 0; i < 15; i++) jq[$urandom_range(0, 1)].push_back(rand_job($urandom_range(0, 4)));
      wait_rsp(base + 15, 3000, "t7_wait");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "bench stopped by watchdog");
  end

endmodule

// File: doc/mp_arbiter.md
# mp_arbiter

Two-port round-robin arbiter and sequencer that shares one `ModuloProduct` unit between independent requesters, such as the RSA exponentiation core and the precompute path. It accepts a request over valid/ready and latches the operands. It then issues a single start pulse to the shared unit, waits for completion under a watchdog, and returns the result tagged to the owning requester. It sits between the requesters and the single `ModuloProduct` instance in the RSA256 core.

## Interface
- `WIDTH`, 256: operand and result width.
- `KW`, 9: width of the bit-count field `k`.
- `TIMEOUT`, 600: maximum cycles to wait for `i_mp_ready` before aborting; must be ≥ 2.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_req_valid`  in  2  per-requester request valid.
- `o_req_ready`  out  2  per-requester accept strobe; one-hot or zero.
- `i_req_N`  in  2×WIDTH  modulus, packed as [1:0][WIDTH-1:0].
- `i_req_a`  in  2×WIDTH  operand a.
- `i_req_b`  in  2×WIDTH  operand b.
- `i_req_k`  in  2×KW  bit count of a.
- `o_rsp_valid`  out  2  one-cycle response strobe, one-hot.
- `o_rsp_data`  out  WIDTH  result, shared bus.
- `o_rsp_err`  out  1  response is a timeout abort.
- `o_mp_rst`  out  1  reset to the shared unit: `i_rst` OR the abort pulse.
- `o_mp_valid`  out  1  start pulse to the shared unit.
- `o_mp_N`  out  WIDTH  latched operand to the shared unit.
- `o_mp_a`  out  WIDTH  latched operand to the shared unit.
- `o_mp_b`  out  WIDTH  latched operand to the shared unit.
- `o_mp_k`  out  KW  latched operand to the shared unit.
- `i_mp_result`  in  WIDTH  result from the shared unit.
- `i_mp_ready`  in  1  completion pulse from the shared unit.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Grant goes to the first valid requester after `last_grant`, in round-robin order.
  - `o_req_ready[g]` is asserted combinationally in the same cycle.
  - On handshake: latch N/a/b/k into `o_mp_*`, record `g`, set `last_grant`=g, go to ISSUE.
- **ISSUE**: `o_mp_valid`=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `i_mp_ready`: latch `i_mp_result`, set err=0, go to DONE.
  - Else if counter = TIMEOUT-1: set result=0, err=1, pulse `o_mp_rst` for one cycle, go to DONE.
  - If `i_mp_ready` arrives in the same cycle as expiry, ready wins (no error).
- **DONE**: `o_rsp_valid[g]`=1 for one cycle with `o_rsp_data`/`o_rsp_err`; go to IDLE.
- `o_mp_N/a/b/k` hold their latched values from ISSUE through DONE.
- `i_mp_ready` is ignored outside WAIT.
- Requester inputs are ignored outside IDLE. A requester holds valid and operands until it sees ready.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (requester 0 wins first).
  - All strobes 0, `o_busy`=0.
  - `o_mp_*` operands 0, `o_rsp_data`=0, `o_rsp_err`=0.
  - `o_mp_rst`=1 while `i_rst` is high.
- Accept in cycle t → `o_mp_valid` at t+1 → WAIT from t+2.
- `i_mp_ready` at cycle u → `o_rsp_valid` at u+1 → next accept possible at u+2.
- Arbitration overhead is 3 cycles per transaction plus the unit's latency.
- Abort: `o_mp_rst` is high in the first DONE cycle.
- Timeout response arrives TIMEOUT+2 cycles after the accept.
- Reset during any state returns to IDLE next edge. Any in-flight transaction is dropped with no response.
- If both requesters hold valid continuously, grants strictly alternate.

## Structure
- Package `mp_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} mp_state_t`;
  - `localparam` defaults for WIDTH/KW;
  - the `mp_req_t` struct {N, a, b, k}.
- One natural sub-module: `rr_arb2`, a combinational two-way round-robin grant from request bits and `last_grant`.
- The FSM, operand latch and watchdog live in `mp_arbiter`.

## Test plan
The bench uses a behavioural `ModuloProduct` stub returning a·b mod N after a programmable latency L.
1. **Single request.** Req0: N=18795, a=1000, b=1000, k=14, L=20.
   - `o_req_ready[0]` in the same cycle; `o_mp_valid` one cycle later.
   - `o_rsp_valid[0]` 1 cycle after the stub ready; `o_rsp_data`=3865, err=0.
2. **Simultaneous requests after reset.** Both valid; req1: N=18795, a=2, b=9400.
   - Req0 is served first (3865), then req1 (5).
   - Exactly one `o_rsp_valid` bit per response.
3. **Continuous contention.** Both valid for 6 transactions → grant order 0,1,0,1,0,1.
4. **Timeout.** Stub never returns ready, TIMEOUT=600.
   - `o_rsp_err`=1 and `o_rsp_data`=0, TIMEOUT+2 cycles after accept.
   - `o_mp_rst` pulses once.
   - A following request completes normally.
5. **Ready at expiry.** Stub ready on the exact expiry cycle → err=0 and the correct result.
6. **Reset mid-WAIT.** Assert `i_rst` during WAIT.
   - No `o_rsp_valid`; `o_busy`=0 the next cycle.
   - A stray stub ready afterwards is ignored; a new request is served with requester 0 priority.
